median_stream: RTL
==================

MEDIAN_STREAM -- requirements
Module: median_stream

Interface
REQ-001 Parameter PIX_W, default 8, pixel width in bits.
REQ-002 Parameter IMG_W, default 320, pixels per line; legal range 4..4096.
REQ-003 Parameter IMG_H, default 240, lines per frame; legal range 3..4096.
REQ-004 Parameter BORDER_MODE, default 0, border output: 0 = zero, 1 = pass the centre input pixel through.
REQ-005 Port clk_i, input, 1, the single clock; all logic rising-edge.
REQ-006 Port rst_i, input, 1, asynchronous active-high reset.
REQ-007 Port start_i, input, 1, one-cycle pulse that arms a frame; ignored unless the state is IDLE.
REQ-008 Port in_data_i, input, PIX_W, raster-order input pixel.
REQ-009 Port in_valid_i / in_ready_o, input / output, 1 each, input handshake; a transfer occurs when both are high.
REQ-010 Port out_data_o, output, PIX_W, filtered pixel.
REQ-011 Port out_valid_o / out_ready_i, output / input, 1 each, output handshake.
REQ-012 Port busy_o, output, 1, high in any state other than IDLE.
REQ-013 Port done_o, output, 1, one-cycle pulse on the cycle the last output pixel of the frame transfers.

Function
REQ-014 FSM states are IDLE, RUN, FLUSH and DRAIN.
- IDLE -> RUN on start_i.
- RUN -> FLUSH after input pixel IMG_W*IMG_H-1 is accepted.
- FLUSH -> DRAIN after IMG_W+1 virtual pixels.
- DRAIN -> IDLE after the last output transfer.
REQ-015 Output pixel (r,c), for 1<=r<=IMG_H-2 and 1<=c<=IMG_W-2, is the median of the 3x3 input neighbourhood centred on (r,c).
REQ-016 Output pixels with r=0, r=IMG_H-1, c=0 or c=IMG_W-1 are 0 when BORDER_MODE=0 and equal input (r,c) when BORDER_MODE=1.
REQ-017 Exactly IMG_W*IMG_H outputs are produced per frame, in raster order, with no gaps in the count and no extra outputs.
REQ-018 Window storage is two line buffers, each IMG_W x PIX_W, plus a 3x3 register window; column and row counters wrap at IMG_W-1 and IMG_H-1.
REQ-019 Output (r,c) is computed when input index (r+1)*IMG_W+c+1 is accepted, or when the equivalent FLUSH step is reached; it is presented on out_*_o exactly 3 enabled cycles later (sorter latency 3).
REQ-020 In FLUSH, the window advances one position per enabled cycle without input, and in_ready_o=0.
REQ-021 Global enable is en = ~out_valid_o | out_ready_i; when en=0, all pipeline, window and counter state holds, and out_data_o stays stable while out_valid_o=1.
REQ-022 in_ready_o = en while in RUN, else 0.
REQ-023 The median is exact for unsigned PIX_W values; there is no rounding and no width growth.
REQ-024 A start_i that coincides with a done_o pulse is ignored; a new frame needs start_i while in IDLE.

Reset
REQ-025 On rst_i, the block enters IDLE immediately, regardless of clock.
REQ-026 Reset drives in_ready_o, out_valid_o, busy_o and done_o to 0, and out_data_o to 0.
REQ-027 Reset clears all counters and pipeline valids; line-buffer contents need not be cleared.
REQ-028 Reset mid-frame discards the frame; the next start_i begins a clean frame, with no residual outputs.

Structure
REQ-029 A shared package holds the state enum, SORT_LAT=3 and the BORDER_ZERO/BORDER_COPY constants.
REQ-030 The sub-module median9_net (PIX_W parameter, 9 inputs, 3-stage pipelined compare-exchange network, enable input) is instantiated once.

Verification (IMG_W=4, IMG_H=4, PIX_W=8)
REQ-031 Constant 50 image, BORDER_MODE=0, out_ready_i=1 -> 16 outputs; the 4 interior outputs are 50 and the 12 border outputs are 0; done_o pulses once.
REQ-032 All pixels 10 except (1,1)=255, BORDER_MODE=1 -> interior outputs all 10; border outputs equal their inputs.
REQ-033 Raster ramp 0..15, BORDER_MODE=0 -> interior outputs (1,1)=5, (1,2)=6, (2,1)=9, (2,2)=10.
REQ-034 Constant-50 case with out_ready_i toggling 1/0 each cycle and in_valid_i random -> output sequence identical to REQ-031; no output is dropped or duplicated.
REQ-035 Assert rst_i after 7 accepted inputs, then start a constant-20 frame -> outputs contain no 50, and exactly 16 outputs are produced.
REQ-036 Two back-to-back frames with start_i in IDLE -> busy_o drops for at least 1 cycle between frames; each frame produces exactly 16 outputs.

Source files
------------

// File: rtl/median_stream_pkg.sv
// Shared types and constants for the streaming 3x3 median filter.
package median_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int unsigned SORT_LAT    = 3;
    localparam int unsigned BORDER_ZERO = 0;
    localparam int unsigned BORDER_COPY = 1;

endpackage

// File: rtl/median9_net.sv
// Three-stage pipelined median-of-nine: sort rows, combine columns, final median-of-three.
module median9_net #(
    parameter int unsigned PIX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [9*PIX_W-1:0]   pix,
    output logic [PIX_W-1:0]     med
);

    typedef logic [PIX_W-1:0] px_t;

    function automatic px_t mn(input px_t a, input px_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic px_t mx(input px_t a, input px_t b);
        return (a < b) ? b : a;
    endfunction

    function automatic px_t med3(input px_t a, input px_t b, input px_t c);
        return mx(mn(a, b), mn(mx(a, b), c));
    endfunction

    px_t pv [9];
    px_t lo [3];
    px_t mid [3];
    px_t hi [3];
    px_t s2_lo, s2_mid, s2_hi;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            pv[i] = pix[i*PIX_W +: PIX_W];
        end
    end

    // Stage 1: sort each row of three.
    for (genvar g = 0; g < 3; g++) begin : g_row
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lo[g]  <= '0;
                mid[g] <= '0;
                hi[g]  <= '0;
            end else if (en) begin
                lo[g]  <= mn(mn(pv[3*g], pv[3*g+1]), pv[3*g+2]);
                mid[g] <= med3(pv[3*g], pv[3*g+1], pv[3*g+2]);
                hi[g]  <= mx(mx(pv[3*g], pv[3*g+1]), pv[3*g+2]);
            end
        end
    end

    // Stages 2 and 3: median = med3(max of lows, med of mids, min of highs).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_lo  <= '0;
            s2_mid <= '0;
            s2_hi  <= '0;
            med    <= '0;
        end else if (en) begin
            s2_lo  <= mx(mx(lo[0], lo[1]), lo[2]);
            s2_mid <= med3(mid[0], mid[1], mid[2]);
            s2_hi  <= mn(mn(hi[0], hi[1]), hi[2]);
            med    <= med3(s2_lo, s2_mid, s2_hi);
        end
    end

endmodule

// File: rtl/median_stream.sv
// Streaming raster 3x3 median filter with two line buffers, flush tail and border handling.
module median_stream
    import median_stream_pkg::*;
#(
    parameter int unsigned PIX_W       = 8,
    parameter int unsigned IMG_W       = 320,
    parameter int unsigned IMG_H       = 240,
    parameter int unsigned BORDER_MODE = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [PIX_W-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [PIX_W-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned FW = $clog2(IMG_W + 1);

    state_t                state;
    logic [CW-1:0]         icol, ocol;
    logic [RW-1:0]         irow, orow;
    logic [FW-1:0]         fcnt;
    logic [SORT_LAT-1:0]   vpipe, lpipe;
    logic [PIX_W-1:0]      lb0 [IMG_W];
    logic [PIX_W-1:0]      lb1 [IMG_W];
    logic [PIX_W-1:0]      win [3][2];

    logic                  en, step, produce, border, last_pos, in_last;
    logic [PIX_W-1:0]      pix_new, col_top, col_mid, fill;
    logic [9*PIX_W-1:0]    net_in;

    assign en          = ~out_valid_o | out_ready_i;
    assign in_ready_o  = (state == RUN) & en;
    assign busy_o      = (state != IDLE);
    assign out_valid_o = vpipe[SORT_LAT-1];
    assign done_o      = out_valid_o & out_ready_i & lpipe[SORT_LAT-1];

    // A step is one window advance: an accepted pixel in RUN, or a virtual one in FLUSH.
    always_comb begin
        step     = 1'b0;
        pix_new  = '0;
        produce  = 1'b0;
        border   = 1'b0;
        last_pos = 1'b0;
        in_last  = 1'b0;
        fill     = '0;
        net_in   = '0;
        if (state == RUN) begin
            step    = in_valid_i & in_ready_o;
            pix_new = in_data_i;
        end else if (state == FLUSH) begin
            step = en;
        end
        col_top  = lb1[icol];
        col_mid  = lb0[icol];
        produce  = (state == FLUSH) || (irow >= RW'(2)) || ((irow == RW'(1)) && (icol != '0));
        in_last  = (icol == CW'(IMG_W - 1)) && (irow == RW'(IMG_H - 1));
        last_pos = (ocol == CW'(IMG_W - 1)) && (orow == RW'(IMG_H - 1));
        border   = (orow == '0) || (orow == RW'(IMG_H - 1)) || (ocol == '0) || (ocol == CW'(IMG_W - 1));
        // Border pixels feed nine copies of one value so the network passes it through.
        if (BORDER_MODE == BORDER_COPY) begin
            fill = win[1][1];
        end
        if (border) begin
            net_in = {9{fill}};
        end else begin
            net_in = {win[0][0], win[0][1], col_top,
                      win[1][0], win[1][1], col_mid,
                      win[2][0], win[2][1], pix_new};
        end
    end

    always_ff @(posedge clk_i) begin
        if (step) begin
            lb1[icol] <= col_mid;
            lb0[icol] <= pix_new;
            win[0][0] <= win[0][1];
            win[1][0] <= win[1][1];
            win[2][0] <= win[2][1];
            win[0][1] <= col_top;
            win[1][1] <= col_mid;
            win[2][1] <= pix_new;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            icol  <= '0;
            irow  <= '0;
            ocol  <= '0;
            orow  <= '0;
            fcnt  <= '0;
            vpipe <= '0;
            lpipe <= '0;
        end else begin
            if (en) begin
                vpipe <= {vpipe[SORT_LAT-2:0], step & produce};
                lpipe <= {lpipe[SORT_LAT-2:0], step & produce & last_pos};
            end
            if (step) begin
                if (icol == CW'(IMG_W - 1)) begin
                    icol <= '0;
                    irow <= (irow == RW'(IMG_H - 1)) ? '0 : irow + RW'(1);
                end else begin
                    icol <= icol + CW'(1);
                end
            end
            if (step && produce) begin
                if (ocol == CW'(IMG_W - 1)) begin
                    ocol <= '0;
                    orow <= (orow == RW'(IMG_H - 1)) ? '0 : orow + RW'(1);
                end else begin
                    ocol <= ocol + CW'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= RUN;
                        icol  <= '0;
                        irow  <= '0;
                        ocol  <= '0;
                        orow  <= '0;
                        fcnt  <= '0;
                    end
                end
                RUN: begin
                    if (step && in_last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (step) begin
                        fcnt <= fcnt + FW'(1);
                        if (fcnt == FW'(IMG_W)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (done_o) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    median9_net #(.PIX_W(PIX_W)) u_net (
        .clk (clk_i),
        .rst (rst_i),
        .en  (en),
        .pix (net_in),
        .med (out_data_o)
    );

endmodule
